lap_stopwatch_core: RTL and testbench

//  Parametrised stopwatch core with integrated key FSM, split (lap) capture and a circular lap

---
 rtl/lap_stopwatch_core_if.sv | 21 ++
 rtl/lap_stopwatch_core.sv | 269 ++++++++++++++++++++++++++
 tb/tb_lap_stopwatch_core.sv | 276 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/lap_stopwatch_core_if.sv
// Lap memory read port: the consumer drives an index (0 = newest lap) and
// receives the registered entry and its valid flag one cycle later.
interface lap_stopwatch_core_if #(
  parameter int unsigned LAP_DEPTH = 8
);
  logic [$clog2(LAP_DEPTH)-1:0] lap_rd_idx;
  logic [24:0]                  lap_rd_data;
  logic                         lap_rd_valid;

  modport master (
    output lap_rd_idx,
    input  lap_rd_data,
    input  lap_rd_valid
  );

  modport slave (
    input  lap_rd_idx,
    output lap_rd_data,
    output lap_rd_valid
  );
endinterface

// File: rtl/lap_stopwatch_core.sv
// Stopwatch core: key edge detection and FSM, prescaled h:m:s.cs counter,
// lap capture into a circular memory and a frozen-lap display mux.
module lap_stopwatch_core #(
  parameter int unsigned CLK_HZ    = 50_000_000,
  parameter int unsigned TICK_HZ   = 100,
  parameter int unsigned HOUR_WRAP = 24,
  parameter int unsigned LAP_DEPTH = 8
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          k_start_pause,
  input  logic                          k_lap,
  input  logic                          k_reset,
  input  logic                          k_clear,
  output logic [5:0]                    hour,
  output logic [5:0]                    minute,
  output logic [5:0]                    second,
  output logic [6:0]                    m_sec,
  output logic                          run_timer,
  output logic                          frozen,
  output logic [$clog2(LAP_DEPTH):0]    lap_count,
  output logic                          lap_overflow,
  lap_stopwatch_core_if.slave           lap_rd
);

  localparam int unsigned DIV = CLK_HZ / TICK_HZ;
  localparam int unsigned PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned IW  = $clog2(LAP_DEPTH);
  localparam int unsigned CW  = IW + 1;

  localparam logic [PW-1:0] PRE_LAST  = PW'(DIV - 1);
  localparam logic [5:0]    HOUR_LAST = 6'(HOUR_WRAP - 1);
  localparam logic [CW-1:0] DEPTH     = CW'(LAP_DEPTH);

  if (DIV < 2 || (CLK_HZ % TICK_HZ) != 0) begin : g_bad_div
    $error("lap_stopwatch_core: CLK_HZ/TICK_HZ must be an integer >= 2");
  end
  if (HOUR_WRAP < 1 || HOUR_WRAP > 64) begin : g_bad_hour
    $error("lap_stopwatch_core: HOUR_WRAP must be in 1..64");
  end
  if (LAP_DEPTH < 2 || LAP_DEPTH > 64 || (LAP_DEPTH & (LAP_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lap_stopwatch_core: LAP_DEPTH must be a power of two in 2..64");
  end

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_LAP_VIEW
  } state_t;

  // ---------------------------------------------------------------- keys
  logic [3:0] key_now;
  logic [3:0] key_prev;
  logic [3:0] key_rise;
  logic       ev_start;
  logic       ev_lap;
  logic       ev_reset;
  logic       ev_clear;

  always_comb begin
    key_now  = {k_clear, k_reset, k_lap, k_start_pause};
    key_rise = key_now & ~key_prev;
    // k_reset beats start, start beats lap; clear is independent
    ev_reset = key_rise[2];
    ev_start = key_rise[0] & ~key_rise[2];
    ev_lap   = key_rise[1] & ~key_rise[2] & ~key_rise[0];
    ev_clear = key_rise[3];
  end

  // Previous levels come out of reset high so a key held through reset is not an edge.
  always_ff @(posedge clock) begin
    if (reset) begin
      key_prev <= '1;
    end else begin
      key_prev <= key_now;
    end
  end

  // ----------------------------------------------------------------- FSM
  state_t state;
  state_t state_nxt;
  logic   push;
  logic   zero_time;

  always_ff @(posedge clock) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    push      = 1'b0;
    zero_time = 1'b0;
    case (state)
      ST_IDLE: begin
        if (ev_start) state_nxt = ST_RUN;
      end
      ST_RUN: begin
        if (ev_start) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lap) begin
          state_nxt = ST_LAP_VIEW;
          push      = 1'b1;
        end
      end
      ST_LAP_VIEW: begin
        if (ev_reset) begin
          state_nxt = ST_RUN;
        end else if (ev_start) begin
          state_nxt = ST_PAUSE;
        end else if (ev_lap) begin
          push = 1'b1;
        end
      end
      ST_PAUSE: begin
        if (ev_start) begin
          state_nxt = ST_RUN;
        end else if (ev_reset) begin
          state_nxt = ST_IDLE;
          zero_time = 1'b1;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    run_timer = (state == ST_RUN) || (state == ST_LAP_VIEW);
    frozen    = (state == ST_LAP_VIEW);
  end

  // ------------------------------------------------------ prescaler/time
  logic [PW-1:0] presc;
  logic          tick;
  logic [6:0]    cs_q;
  logic [5:0]    sec_q;
  logic [5:0]    min_q;
  logic [5:0]    hour_q;
  logic          cs_wrap;
  logic          sec_wrap;
  logic          min_wrap;
  logic          hour_wrap;

  always_comb begin
    tick      = run_timer && (presc == PRE_LAST);
    cs_wrap   = (cs_q == 7'd99);
    sec_wrap  = (sec_q == 6'd59);
    min_wrap  = (min_q == 6'd59);
    hour_wrap = (hour_q == HOUR_LAST);
  end

  // Prescaler only advances while running, so a pause keeps the partial tick.
  always_ff @(posedge clock) begin
    if (reset || zero_time) begin
      presc <= '0;
    end else if (run_timer) begin
      presc <= tick ? '0 : presc + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset || zero_time) begin
      cs_q   <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
    end else if (tick) begin
      cs_q <= cs_wrap ? '0 : cs_q + 7'd1;
      if (cs_wrap) begin
        sec_q <= sec_wrap ? '0 : sec_q + 6'd1;
        if (sec_wrap) begin
          min_q <= min_wrap ? '0 : min_q + 6'd1;
          if (min_wrap) begin
            hour_q <= hour_wrap ? '0 : hour_q + 6'd1;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------- lap memory
  logic [24:0]   live_time;
  logic [24:0]   last_lap;
  logic [24:0]   lap_mem [LAP_DEPTH];
  logic [IW-1:0] wr_ptr;
  logic [IW-1:0] wr_addr;
  logic [CW-1:0] count_q;
  logic          ovf_q;

  always_comb begin
    live_time = {hour_q, min_q, sec_q, cs_q};
    // A clear in the same cycle as a push restarts the ring before the write.
    wr_addr   = ev_clear ? '0 : wr_ptr;
  end

  always_ff @(posedge clock) begin
    if (push) begin
      lap_mem[wr_addr] <= live_time;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr   <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      last_lap <= '0;
    end else begin
      if (ev_clear) begin
        wr_ptr  <= '0;
        count_q <= '0;
        ovf_q   <= 1'b0;
      end
      if (push) begin
        wr_ptr   <= wr_addr + 1'b1;
        last_lap <= live_time;
        if (ev_clear) begin
          count_q <= CW'(1);
        end else if (count_q == DEPTH) begin
          ovf_q <= 1'b1;
        end else begin
          count_q <= count_q + 1'b1;
        end
      end
    end
  end

  always_comb begin
    lap_count    = count_q;
    lap_overflow = ovf_q;
  end

  // ----------------------------------------------------------- read port
  logic [IW-1:0] rd_addr;
  logic          rd_hit;
  logic [24:0]   rd_data_q;
  logic          rd_valid_q;

  always_comb begin
    // Index 0 is the entry just behind the write pointer.
    rd_addr = wr_ptr - lap_rd.lap_rd_idx - 1'b1;
    rd_hit  = ({1'b0, lap_rd.lap_rd_idx} < count_q);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_valid_q <= rd_hit;
      rd_data_q  <= rd_hit ? lap_mem[rd_addr] : '0;
    end
  end

  always_comb begin
    lap_rd.lap_rd_data  = rd_data_q;
    lap_rd.lap_rd_valid = rd_valid_q;
  end

  // ------------------------------------------------------------- display
  always_comb begin
    {hour, minute, second, m_sec} = frozen ? last_lap : live_time;
  end

endmodule

// File: tb/tb_lap_stopwatch_core.sv
// Directed bench for lap_stopwatch_core: three instances (default, HOUR_WRAP=1,
// LAP_DEPTH=4) at CLK_HZ=1000, TICK_HZ=100 so one tick every 10 clocks.
module tb_lap_stopwatch_core;

  localparam logic [3:0] START = 4'b0001;
  localparam logic [3:0] LAP   = 4'b0010;
  localparam logic [3:0] RST   = 4'b0100;
  localparam logic [3:0] CLR   = 4'b1000;

  logic       clock = 1'b0;
  logic [2:0] rst   = '1;
  logic [2:0] k_start = '0;
  logic [2:0] k_lap   = '0;
  logic [2:0] k_reset = '0;
  logic [2:0] k_clear = '0;
  logic [5:0] rd_idx [3];

  logic [5:0]  hour [3];
  logic [5:0]  minute [3];
  logic [5:0]  second [3];
  logic [6:0]  m_sec [3];
  logic        run_timer [3];
  logic        frozen [3];
  logic [6:0]  lap_count [3];
  logic        lap_overflow [3];
  logic [24:0] rd_data [3];
  logic        rd_valid [3];

  int unsigned vectors = 0;
  int unsigned miscompares = 0;

  always #5 clock = ~clock;

  for (genvar g = 0; g < 3; g++) begin : gen_dut
    localparam int unsigned LD = (g == 2) ? 4 : 8;
    localparam int unsigned HW = (g == 1) ? 1 : 24;
    localparam int unsigned IW = $clog2(LD);

    logic [IW:0] cnt;

    lap_stopwatch_core_if #(.LAP_DEPTH(LD)) rd ();

    assign rd.lap_rd_idx = rd_idx[g][IW-1:0];

    lap_stopwatch_core #(
      .CLK_HZ   (1000),
      .TICK_HZ  (100),
      .HOUR_WRAP(HW),
      .LAP_DEPTH(LD)
    ) dut (
      .clock        (clock),
      .reset        (rst[g]),
      .k_start_pause(k_start[g]),
      .k_lap        (k_lap[g]),
      .k_reset      (k_reset[g]),
      .k_clear      (k_clear[g]),
      .hour         (hour[g]),
      .minute       (minute[g]),
      .second       (second[g]),
      .m_sec        (m_sec[g]),
      .run_timer    (run_timer[g]),
      .frozen       (frozen[g]),
      .lap_count    (cnt),
      .lap_overflow (lap_overflow[g]),
      .lap_rd       (rd.slave)
    );

    assign lap_count[g] = 7'(cnt);
    assign rd_data[g]   = rd.lap_rd_data;
    assign rd_valid[g]  = rd.lap_rd_valid;
  end

  function automatic logic [24:0] tv(input int h, input int m, input int s, input int c);
    logic [31:0] hh, mm, ss, cc;
    hh = h; mm = m; ss = s; cc = c;
    return {hh[5:0], mm[5:0], ss[5:0], cc[6:0]};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_time(input int g, input string tag, input logic [24:0] exp);
    chk(tag, 32'({hour[g], minute[g], second[g], m_sec[g]}), 32'(exp));
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clock);
  endtask

  // One-cycle key pulse; returns on the negedge after the sampling posedge.
  task automatic press(input int g, input logic [3:0] m);
    k_start[g] = m[0];
    k_lap[g]   = m[1];
    k_reset[g] = m[2];
    k_clear[g] = m[3];
    @(negedge clock);
    k_start[g] = 1'b0;
    k_lap[g]   = 1'b0;
    k_reset[g] = 1'b0;
    k_clear[g] = 1'b0;
  endtask

  task automatic rd_chk(input int g, input int idx, input string tag,
                        input logic valid, input logic [24:0] data);
    rd_idx[g] = 6'(idx);
    cyc(1);
    chk({tag, " valid"}, 32'(rd_valid[g]), 32'(valid));
    chk({tag, " data"}, 32'(rd_data[g]), 32'(data));
  endtask

  initial begin
    for (int i = 0; i < 3; i++) rd_idx[i] = '0;
    cyc(3);

    // reset state
    chk_time(0, "rst time", tv(0, 0, 0, 0));
    chk("rst run_timer", 32'(run_timer[0]), 32'd0);
    chk("rst frozen", 32'(frozen[0]), 32'd0);
    chk("rst lap_count", 32'(lap_count[0]), 32'd0);
    chk("rst overflow", 32'(lap_overflow[0]), 32'd0);
    chk("rst rd_data", 32'(rd_data[0]), 32'd0);
    chk("rst rd_valid", 32'(rd_valid[0]), 32'd0);
    rst = '0;
    cyc(2);

    // 1: count, pause, resume with held prescaler
    press(0, START);
    chk("t1 run", 32'(run_timer[0]), 32'd1);
    cyc(999);
    chk_time(0, "t1 0.99", tv(0, 0, 0, 99));
    cyc(1);
    chk_time(0, "t1 1.00", tv(0, 0, 1, 0));
    press(0, START);
    chk("t1 paused", 32'(run_timer[0]), 32'd0);
    cyc(500);
    chk_time(0, "t1 pause hold", tv(0, 0, 1, 0));
    press(0, START);
    cyc(8);
    chk_time(0, "t1 resume pre", tv(0, 0, 1, 0));
    cyc(1);
    chk_time(0, "t1 resume tick", tv(0, 0, 1, 1));

    rst[0] = 1'b1;
    cyc(1);
    chk_time(0, "t1 port reset", tv(0, 0, 0, 0));
    chk("t1 port reset run", 32'(run_timer[0]), 32'd0);
    cyc(1);
    rst[0] = 1'b0;
    cyc(2);

    // 3: laps at 0.50 (on a tick edge), 1.20, 3.00
    press(0, START);
    cyc(509);
    press(0, LAP);
    chk("t3 frozen", 32'(frozen[0]), 32'd1);
    chk("t3 run", 32'(run_timer[0]), 32'd1);
    chk("t3 count1", 32'(lap_count[0]), 32'd1);
    chk_time(0, "t3 lap1 view", tv(0, 0, 0, 50));
    cyc(690);
    press(0, LAP);
    chk_time(0, "t3 lap2 view", tv(0, 0, 1, 20));
    cyc(1799);
    press(0, LAP);
    chk("t3 count3", 32'(lap_count[0]), 32'd3);
    chk_time(0, "t3 lap3 view", tv(0, 0, 3, 0));
    cyc(100);
    chk_time(0, "t3 frozen view", tv(0, 0, 3, 0));
    chk("t3 still frozen", 32'(frozen[0]), 32'd1);
    rd_chk(0, 0, "t3 idx0", 1'b1, tv(0, 0, 3, 0));
    rd_chk(0, 1, "t3 idx1", 1'b1, tv(0, 0, 1, 20));
    rd_chk(0, 2, "t3 idx2", 1'b1, tv(0, 0, 0, 50));
    rd_chk(0, 3, "t3 idx3", 1'b0, tv(0, 0, 0, 0));
    press(0, RST);
    chk("t3 unfrozen", 32'(frozen[0]), 32'd0);
    chk("t3 unfrozen run", 32'(run_timer[0]), 32'd1);
    chk_time(0, "t3 live", tv(0, 0, 3, 10));

    // 5: k_reset in RUN ignored; start+lap; k_reset in PAUSE
    cyc(1);
    press(0, RST);
    chk("t5 rst in run", 32'(run_timer[0]), 32'd1);
    chk_time(0, "t5 rst in run time", tv(0, 0, 3, 10));
    press(0, START | LAP);
    chk("t5 start+lap run", 32'(run_timer[0]), 32'd0);
    chk("t5 start+lap count", 32'(lap_count[0]), 32'd3);
    chk_time(0, "t5 paused time", tv(0, 0, 3, 10));
    press(0, RST);
    chk_time(0, "t5 user reset", tv(0, 0, 0, 0));
    chk("t5 idle", 32'(run_timer[0]), 32'd0);
    chk("t5 laps kept", 32'(lap_count[0]), 32'd3);
    rd_chk(0, 0, "t5 idx0 kept", 1'b1, tv(0, 0, 3, 0));
    press(0, START);
    cyc(9);
    chk_time(0, "t5 presc zeroed pre", tv(0, 0, 0, 0));
    cyc(1);
    chk_time(0, "t5 presc zeroed tick", tv(0, 0, 0, 1));

    // 2: HOUR_WRAP=1 rollover from 0:59:59.99
    force gen_dut[1].dut.min_q = 6'd59;
    force gen_dut[1].dut.sec_q = 6'd59;
    force gen_dut[1].dut.cs_q  = 7'd99;
    cyc(1);
    release gen_dut[1].dut.min_q;
    release gen_dut[1].dut.sec_q;
    release gen_dut[1].dut.cs_q;
    chk_time(1, "t2 preset", tv(0, 59, 59, 99));
    press(1, START);
    cyc(9);
    chk_time(1, "t2 before wrap", tv(0, 59, 59, 99));
    cyc(1);
    chk_time(1, "t2 wrap", tv(0, 0, 0, 0));
    chk("t2 run after wrap", 32'(run_timer[1]), 32'd1);
    cyc(10);
    chk_time(1, "t2 keeps running", tv(0, 0, 0, 1));

    // 4: LAP_DEPTH=4 overflow and clear
    press(2, START);
    cyc(50);
    press(2, LAP);
    cyc(49);
    press(2, LAP);
    cyc(49);
    press(2, LAP);
    cyc(49);
    press(2, LAP);
    chk("t4 full count", 32'(lap_count[2]), 32'd4);
    chk("t4 full no ovf", 32'(lap_overflow[2]), 32'd0);
    cyc(49);
    press(2, LAP);
    chk("t4 ovf count", 32'(lap_count[2]), 32'd4);
    chk("t4 ovf flag", 32'(lap_overflow[2]), 32'd1);
    chk_time(2, "t4 lap5 view", tv(0, 0, 0, 25));
    rd_chk(2, 0, "t4 idx0", 1'b1, tv(0, 0, 0, 25));
    rd_chk(2, 3, "t4 idx3", 1'b1, tv(0, 0, 0, 10));
    rd_chk(2, 1, "t4 idx1", 1'b1, tv(0, 0, 0, 20));
    press(2, CLR);
    chk("t4 clear count", 32'(lap_count[2]), 32'd0);
    chk("t4 clear ovf", 32'(lap_overflow[2]), 32'd0);
    rd_chk(2, 0, "t4 cleared idx0", 1'b0, tv(0, 0, 0, 0));
    cyc(10);
    press(2, CLR | LAP);
    chk("t4 clear+lap count", 32'(lap_count[2]), 32'd1);
    chk("t4 clear+lap ovf", 32'(lap_overflow[2]), 32'd0);
    chk_time(2, "t4 clear+lap view", tv(0, 0, 0, 26));
    rd_chk(2, 0, "t4 clear+lap idx0", 1'b1, tv(0, 0, 0, 26));
    rd_chk(2, 1, "t4 clear+lap idx1", 1'b0, tv(0, 0, 0, 0));

    // 6: port reset mid-run, key held through reset
    rst[2] = 1'b1;
    cyc(1);
    chk_time(2, "t6 reset zeros", tv(0, 0, 0, 0));
    chk("t6 reset run", 32'(run_timer[2]), 32'd0);
    chk("t6 reset frozen", 32'(frozen[2]), 32'd0);
    chk("t6 reset count", 32'(lap_count[2]), 32'd0);
    chk("t6 reset rd_valid", 32'(rd_valid[2]), 32'd0);
    k_start[2] = 1'b1;
    cyc(2);
    rst[2] = 1'b0;
    cyc(3);
    chk("t6 held key no event", 32'(run_timer[2]), 32'd0);
    k_start[2] = 1'b0;
    cyc(2);
    chk("t6 release no event", 32'(run_timer[2]), 32'd0);
    press(2, START);
    chk("t6 fresh start", 32'(run_timer[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
